// File: rtl/change_mult_seq_if.sv
// Operand/result bus between the change detector, the sequential multiplier and the next stage.
interface change_mult_seq_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0]   a_in;
   logic [WIDTH-1:0]   b_in;
   logic               changed;
   logic               busy;
   logic               valid;
   logic [2*WIDTH-1:0] product;

   modport master (output a_in, b_in, changed, input busy, valid, product);
   modport slave  (input a_in, b_in, changed, output busy, valid, product);
endinterface

// File: rtl/change_mult_seq.sv
// Shift-add multiplier started by the change detector's `changed` flag; one-cycle valid per product.
// Optional ZERO_SKIP_EN: a zero operand at capture jumps straight to DONE with product=0.
module change_mult_seq #(
   parameter int WIDTH = 8
) (
   input logic             clk,
   input logic             rst,
   change_mult_seq_if.slave bus
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] product_q, product_d;

   logic [2*WIDTH-1:0] addend, acc_step;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      addend    = mplier_q[0] ? ({{WIDTH{1'b0}}, mcand_q} << cnt_q) : '0;
      acc_step  = acc_q + addend;

      // A new operand pair wins in every state, including over the final iteration.
      if (bus.changed) begin
         mcand_d  = bus.a_in;
         mplier_d = bus.b_in;
         acc_d    = '0;
         cnt_d    = '0;
         state_d  = BUSY;
`ifdef ZERO_SKIP_EN
         if (bus.a_in == '0 || bus.b_in == '0) begin
            state_d   = DONE;
            product_d = '0;
         end
`endif
      end else begin
         case (state_q)
            IDLE: state_d = IDLE;
            BUSY: begin
               acc_d    = acc_step;
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  product_d = acc_step;
                  state_d   = DONE;
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   assign bus.busy    = (state_q == BUSY);
   assign bus.valid   = (state_q == DONE);
   assign bus.product = product_q;
endmodule

// File: tb/tb_change_mult_seq.sv
// Directed bench for change_mult_seq: vector table plus restart, reset and DONE-recapture sequences.
module tb_change_mult_seq;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad = 0;
   logic [2*W-1:0] last_prod = '0;

   always #5 clk = ~clk;

   change_mult_seq_if #(.WIDTH(W)) bus ();
   change_mult_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [2*W-1:0] p;
   } vec_t;
   vec_t vecs[8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_outs(input string nm, input logic [2*W-1:0] p);
      chk({nm, "_busy"}, 32'(bus.busy), 32'd0);
      chk({nm, "_valid"}, 32'(bus.valid), 32'd0);
      chk({nm, "_prod"}, 32'(bus.product), 32'(p));
   endtask

   // Drive a capture; returns just after the capture edge with changed low again.
   task automatic capture(input logic [W-1:0] a, input logic [W-1:0] b);
      bus.a_in = a;
      bus.b_in = b;
      bus.changed = 1'b1;
      tick();
      bus.changed = 1'b0;
   endtask

   // Called just after the capture edge; checks busy window, valid pulse and product.
   task automatic expect_result(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [2*W-1:0] exp);
`ifdef ZERO_SKIP_EN
      if (a == '0 || b == '0) begin
         chk({nm, "_zs_valid"}, 32'(bus.valid), 32'd1);
         chk({nm, "_zs_prod"}, 32'(bus.product), 32'(exp));
         tick();
         chk({nm, "_zs_vdrop"}, 32'(bus.valid), 32'd0);
         last_prod = exp;
         return;
      end
`endif
      for (int i = 0; i < W; i++) begin
         chk($sformatf("%s_busy%0d", nm, i), 32'(bus.busy), 32'd1);
         chk($sformatf("%s_nov%0d", nm, i), 32'(bus.valid), 32'd0);
         chk($sformatf("%s_hold%0d", nm, i), 32'(bus.product), 32'(last_prod));
         tick();
      end
      chk({nm, "_valid"}, 32'(bus.valid), 32'd1);
      chk({nm, "_busy_end"}, 32'(bus.busy), 32'd0);
      chk({nm, "_prod"}, 32'(bus.product), 32'(exp));
      last_prod = exp;
      tick();
      chk({nm, "_vdrop"}, 32'(bus.valid), 32'd0);
      chk({nm, "_prod_hold"}, 32'(bus.product), 32'(exp));
   endtask

   initial begin
      vecs[0] = '{a: 8'd12,  b: 8'd13,  p: 16'h009C};
      vecs[1] = '{a: 8'd255, b: 8'd255, p: 16'hFE01};
      vecs[2] = '{a: 8'd0,   b: 8'd200, p: 16'h0000};
      vecs[3] = '{a: 8'd1,   b: 8'd1,   p: 16'h0001};
      vecs[4] = '{a: 8'd128, b: 8'd2,   p: 16'h0100};
      vecs[5] = '{a: 8'd100, b: 8'd100, p: 16'h2710};
      vecs[6] = '{a: 8'd200, b: 8'd0,   p: 16'h0000};
      vecs[7] = '{a: 8'd170, b: 8'd85,  p: 16'h3872};

      // Reset with arbitrary inputs, changed asserted while held in reset.
      bus.a_in = 8'hA5;
      bus.b_in = 8'h5A;
      bus.changed = 1'b1;
      repeat (3) tick();
      check_idle_outs("rst", 16'h0);
      bus.changed = 1'b0;
      #2 rst = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         check_idle_outs($sformatf("idle%0d", i), 16'h0);
      end

      for (int i = 0; i < 8; i++) begin
         capture(vecs[i].a, vecs[i].b);
         expect_result($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p);
         repeat (2) tick();
      end

      // Restart in BUSY cycle 4: 12*13 abandoned, 3*7 completes.
      capture(8'd12, 8'd13);
      repeat (3) tick();
      capture(8'd3, 8'd7);
      expect_result("restart", 8'd3, 8'd7, 16'h0015);
      tick();

      // Restart on the final-iteration edge: no DONE for the first pair.
      capture(8'd9, 8'd9);
      repeat (7) tick();
      capture(8'd11, 8'd5);
      chk("lastedge_nov", 32'(bus.valid), 32'd0);
      chk("lastedge_prod", 32'(bus.product), 32'(last_prod));
      expect_result("lastedge", 8'd11, 8'd5, 16'h0037);
      tick();

      // changed during DONE recaptures; valid still drops.
      capture(8'd6, 8'd7);
      repeat (7) tick();
      chk("done_pre", 32'(bus.busy), 32'd1);
      tick();
      chk("done_valid", 32'(bus.valid), 32'd1);
      chk("done_prod", 32'(bus.product), 32'd42);
      last_prod = 16'd42;
      capture(8'd20, 8'd30);
      expect_result("done_rc", 8'd20, 8'd30, 16'd600);
      tick();

      // Asynchronous reset mid-operation.
      capture(8'd100, 8'd100);
      repeat (4) tick();
      #2 rst = 1'b0;
      #1;
      check_idle_outs("midrst", 16'h0);
      last_prod = '0;
      for (int i = 0; i < 12; i++) begin
         tick();
         chk($sformatf("midrst_nov%0d", i), 32'(bus.valid), 32'd0);
      end
      rst = 1'b1;
      tick();
      check_idle_outs("post_rst", 16'h0);
      capture(8'd100, 8'd100);
      expect_result("post_rst_mul", 8'd100, 8'd100, 16'h2710);

      repeat (2) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
